// File: rtl/mem_stage.sv
// Memory stage: data-memory load/store over a req/ack port, branch resolution, registered write-back.
// Optional request timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
   parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic              zero,
   input  logic [DATA_W-1:0] branch_target,
   input  logic [4:0]        rd,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              branch,
   input  logic              reg_write,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [4:0]        wb_rd,
   output logic              wb_reg_write,
   output logic              pc_src,
   output logic [DATA_W-1:0] pc_target,
   output logic              misalign_err,
   output logic              timeout_err,
   output logic              dbg_state
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t state, state_nxt;

   logic       mem_op;
   logic       aligned;
   logic       issue;
   logic       alu_op;
   logic       misalign;
   logic       done;
   logic       expire;
   logic       load_q;
   logic       reg_write_q;
   logic [4:0] rd_q;

   // Handshakes: upstream transfers when valid_in=1 and stall=0 on a rising edge; the memory
   // transfer completes on the edge where dmem_req=1 and dmem_ack=1, and req/addr/wdata hold until then.
   assign mem_op   = mem_read | mem_write;
   assign aligned  = (alu_result[1:0] == 2'b00);
   assign issue    = (state == IDLE) && valid_in && mem_op && aligned;
   assign alu_op   = (state == IDLE) && valid_in && !mem_op;
   assign misalign = (state == IDLE) && valid_in && mem_op && !aligned;
   assign done     = (state == REQ) && dmem_ack;

   assign stall     = reset && (issue || ((state == REQ) && !dmem_ack && !expire));
   assign dbg_state = (state == REQ);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = REQ;
         REQ:     if (done || expire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         wb_valid     <= 1'b0;
         wb_data      <= '0;
         wb_rd        <= 5'd0;
         wb_reg_write <= 1'b0;
         pc_src       <= 1'b0;
         pc_target    <= '0;
         misalign_err <= 1'b0;
         load_q       <= 1'b0;
         reg_write_q  <= 1'b0;
         rd_q         <= 5'd0;
      end else begin
         wb_valid     <= 1'b0;
         pc_src       <= 1'b0;
         misalign_err <= misalign;
         if (alu_op) begin
            wb_valid     <= 1'b1;
            wb_data      <= alu_result;
            wb_rd        <= rd;
            wb_reg_write <= reg_write;
            pc_src       <= branch & zero;
            pc_target    <= branch_target;
         end
         if (issue) begin
            dmem_req    <= 1'b1;
            dmem_we     <= mem_write & ~mem_read;
            dmem_addr   <= alu_result;
            dmem_wdata  <= store_data;
            load_q      <= mem_read;
            reg_write_q <= reg_write;
            rd_q        <= rd;
         end
         if (done) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= rd_q;
            wb_reg_write <= load_q & reg_write_q;
            if (load_q) wb_data <= dmem_rdata;
         end
         if (expire) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
         end
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wait_cnt;

   // An ack arriving on the expiry edge still completes normally.
   assign expire = (state == REQ) && !dmem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= expire;
         if (issue)                              wait_cnt <= '0;
         else if ((state == REQ) && !dmem_ack)   wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed steps then random instructions, scoreboarded write-back records.
module tb_mem_stage;
  localparam int W     = 32;
  localparam int REC_W = 71;
  localparam int CW    = 160;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid_in = 1'b0;
  logic [W-1:0]  alu_result = '0;
  logic [W-1:0]  store_data = '0;
  logic          zero = 1'b0;
  logic [W-1:0]  branch_target = '0;
  logic [4:0]    rd = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic          branch = 1'b0;
  logic          reg_write = 1'b0;
  logic          stall;
  logic          dmem_req;
  logic          dmem_we;
  logic [W-1:0]  dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic [W-1:0]  dmem_rdata = '0;
  logic          dmem_ack = 1'b0;
  logic          wb_valid;
  logic [W-1:0]  wb_data;
  logic [4:0]    wb_rd;
  logic          wb_reg_write;
  logic          pc_src;
  logic [W-1:0]  pc_target;
  logic          misalign_err;
  logic          timeout_err;
  logic          dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int exp_mis = 0;
  int obs_mis = 0;

  // record = {wb_data, wb_rd, wb_reg_write, pc_src, pc_target}
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] mask_q[$];
  logic [REC_W-1:0] mon_e;
  logic [REC_W-1:0] mon_m;

  mem_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .zero(zero), .branch_target(branch_target), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .reg_write(reg_write),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_src(pc_src), .pc_target(pc_target), .misalign_err(misalign_err),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [CW-1:0] all_outs();
    return CW'({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_data, wb_rd,
                wb_reg_write, pc_src, pc_target, misalign_err, timeout_err, dbg_state});
  endfunction

  // scoreboard: every write-back pulse must match the oldest predicted record
  always @(negedge clk) begin
    if (reset) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", CW'(wb_valid), CW'(0));
        end else begin
          mon_e = exp_q.pop_front();
          mon_m = mask_q.pop_front();
          check("wb_record", CW'({wb_data, wb_rd, wb_reg_write, pc_src, pc_target} & mon_m),
                CW'(mon_e & mon_m));
        end
      end else if (pc_src) begin
        check("pc_src_without_wb", CW'(pc_src), CW'(0));
      end
      if (misalign_err) obs_mis++;
    end
  end

  // driver: idle cycles, with stray acks that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      @(negedge clk);
      check("req_idle", CW'(dmem_req), CW'(0));
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  // driver + reference model: one instruction, memory answers in its d-th request cycle
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] sd, input logic [W-1:0] bt,
                      input logic z, input logic br, input logic mr, input logic mw,
                      input logic rw, input logic [4:0] r, input int d, input logic [W-1:0] rdat);
    logic memop;
    logic al;
    memop = mr | mw;
    al    = (a[1:0] == 2'b00);
    valid_in = 1'b1; alu_result = a; store_data = sd; branch_target = bt; zero = z;
    branch = br; mem_read = mr; mem_write = mw; reg_write = rw; rd = r; dmem_ack = 1'b0;
    if (!memop) begin
      exp_q.push_back({a, r, rw, br & z, bt});
      mask_q.push_back({REC_W{1'b1}});
    end else if (!al) begin
      exp_mis++;
    end else if (mr) begin
      exp_q.push_back({rdat, r, rw, 1'b0, {W{1'b0}}});
      mask_q.push_back({{W{1'b1}}, 5'h1f, 2'b11, {W{1'b0}}});
    end else begin
      exp_q.push_back({{W{1'b0}}, 5'h00, 1'b0, 1'b0, {W{1'b0}}});
      mask_q.push_back({{W{1'b0}}, 5'h00, 2'b11, {W{1'b0}}});
    end
    @(negedge clk);
    check("req_before_issue", CW'(dmem_req), CW'(0));
    check("stall_accept", CW'(stall), CW'(memop && al));
    @(posedge clk); #1;
    if (memop && al) begin
      for (int k = 1; k <= d; k++) begin
        dmem_ack   = (k == d);
        dmem_rdata = (k == d) ? rdat : $urandom;
        @(negedge clk);
        check("dmem_bus", CW'({dmem_req, dmem_we, dmem_addr, dmem_wdata}),
              CW'({1'b1, mw & ~mr, a, sd}));
        check("stall_req", CW'(stall), CW'(k != d));
        check("timeout_quiet", CW'(timeout_err), CW'(0));
        @(posedge clk); #1;
      end
      dmem_ack = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] a;
    int op;
    #2;
    check("reset_state", all_outs(), CW'(0));
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // directed
    send(32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 0, 32'h0);
    send(32'h77, 32'h0, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0, 32'h0);
    send(32'h78, 32'h0, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0, 32'h0);
    idle(2);
    send(32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 3, 32'hDEADBEEF);
    send(32'h104, 32'h5A, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 2, 32'h0);
    send(32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1, 32'h0);
    idle(2);
    send(32'h200, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1, 32'h12345678);
    send(32'h204, 32'h9, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1, 32'hCAFEF00D);
    send(32'h208, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 0, 32'h0);

    // reset in the middle of an outstanding load
    valid_in = 1'b1; alu_result = 32'h300; mem_read = 1'b1; mem_write = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("reset_mid_req", all_outs(), CW'(0));
    valid_in = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    valid_in = 1'b1; alu_result = 32'h400; mem_read = 1'b1; mem_write = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("timeout_wait", CW'({dmem_req, timeout_err, stall}), CW'({1'b1, 1'b0, k != 16}));
      @(posedge clk); #1;
    end
    valid_in = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check("timeout_abort", CW'({dmem_req, timeout_err, wb_valid, stall}), CW'(4'b0100));
    @(posedge clk); #1;
`else
    send(32'h400, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 20, 32'hA5A5A5A5);
`endif

    // random
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      a  = $urandom;
      case (op)
        0: send(a, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 0, 32'h0);
        1: send(a, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 0, 32'h0);
        2: begin
          a[1:0] = 2'b00;
          send(a, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), $urandom_range(1, 6), $urandom);
        end
        3: begin
          a[1:0] = 2'b00;
          send(a, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'b0, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               $urandom_range(1, 6), $urandom);
        end
        default: begin
          a[1:0] = 2'($urandom_range(1, 3));
          send(a, $urandom, $urandom, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1,
               1'b1, 5'($urandom_range(0, 31)), 1, $urandom);
        end
      endcase
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    check("queue_drained", CW'(exp_q.size()), CW'(0));
    check("misalign_count", CW'(obs_mis), CW'(exp_mis));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
